// File: rtl/serdes_bitslip_align_ctrl_if.sv
// serdes_bitslip_align_ctrl_if: SERDES parallel-side bundle between the deserializer and its alignment controller
//   dpa_ready  : SERDES DPA lock indication
//   data_valid : qualifies data_i for one clk
//   data_i     : deserialized word, WIDTH bits
//   bitslip_n  : active-low bitslip request back to the SERDES
//   modport master = SERDES side, modport slave = alignment controller
interface serdes_bitslip_align_ctrl_if #(
   parameter int WIDTH = 3
);
   logic             dpa_ready;
   logic             data_valid;
   logic [WIDTH-1:0] data_i;
   logic             bitslip_n;
   modport master (output dpa_ready, data_valid, data_i, input bitslip_n);
   modport slave (input dpa_ready, data_valid, data_i, output bitslip_n);
endinterface

// File: rtl/serdes_bitslip_align_ctrl.sv
// serdes_bitslip_align_ctrl: issues SERDES bitslips until a training pattern repeats, then reports lock
//   clk, reset (sync, active-high), enable_n (active-low, high forces idle)
//   bus        : slave side of serdes_bitslip_align_ctrl_if (dpa_ready, data_valid, data_i in; bitslip_n out)
//   aligned    : high while locked
//   align_fail : high once MAX_SLIPS slips did not find the pattern
//   slip_count : slips issued in the current attempt
//   BITSLIP_RELOCK_EN : when defined, LOSS_THRESH consecutive mismatches while locked restart the search
module serdes_bitslip_align_ctrl #(
   parameter int               WIDTH         = 3,
   parameter logic [WIDTH-1:0] TRAIN_PATTERN = 3'b100,
   parameter int               MATCH_COUNT   = 8,
   parameter int               SLIP_WAIT     = 4,
   parameter int               MAX_SLIPS     = 6,
   parameter int               LOSS_THRESH   = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable_n,
   serdes_bitslip_align_ctrl_if.slave     bus,
   output logic                           aligned,
   output logic                           align_fail,
   output logic [$clog2(MAX_SLIPS+1)-1:0] slip_count
);
   localparam int MW = $clog2(MATCH_COUNT + 1);
   localparam int SW = SLIP_WAIT > 0 ? $clog2(SLIP_WAIT + 1) : 1;
   localparam int CW = $clog2(MAX_SLIPS + 1);
   typedef enum logic [2:0] {IDLE, WAIT_READY, CHECK, SLIP, SETTLE, LOCKED, FAIL} state_t;
   state_t state, state_nxt;
   logic [MW-1:0] match_cnt, match_nxt;
   logic [SW-1:0] settle_cnt, settle_nxt;
   logic [CW-1:0] slip_nxt;
   logic bitslip_nxt, aligned_nxt, fail_nxt;
   logic hit, miss, drop, lost;
   assign hit  = bus.data_valid && bus.data_i == TRAIN_PATTERN;
   assign miss = bus.data_valid && bus.data_i != TRAIN_PATTERN;
   // losing DPA only matters once the search has started; FAIL sticks until enable_n or reset
   assign drop = !bus.dpa_ready && state inside {CHECK, SLIP, SETTLE, LOCKED};
`ifdef BITSLIP_RELOCK_EN
   localparam int LW = $clog2(LOSS_THRESH + 1);
   logic [LW-1:0] loss_cnt;
   assign lost = state == LOCKED && miss && loss_cnt == LW'(LOSS_THRESH - 1);
   always_ff @(posedge clk)
      if (reset || state != LOCKED || state_nxt != LOCKED) loss_cnt <= '0;
      else if (bus.data_valid) loss_cnt <= hit ? '0 : loss_cnt + 1'b1;
`else
   assign lost = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         match_cnt     <= '0;
         settle_cnt    <= '0;
         slip_count    <= '0;
         bus.bitslip_n <= 1'b1;
         aligned       <= 1'b0;
         align_fail    <= 1'b0;
      end else begin
         state         <= state_nxt;
         match_cnt     <= match_nxt;
         settle_cnt    <= settle_nxt;
         slip_count    <= slip_nxt;
         bus.bitslip_n <= bitslip_nxt;
         aligned       <= aligned_nxt;
         align_fail    <= fail_nxt;
      end
   end
   always_comb begin
      state_nxt = state;
      if (enable_n) state_nxt = IDLE;
      else if (drop) state_nxt = WAIT_READY;
      else
         case (state)
            IDLE:       state_nxt = WAIT_READY;
            WAIT_READY: state_nxt = bus.dpa_ready ? CHECK : WAIT_READY;
            CHECK:      state_nxt = hit && match_cnt == MW'(MATCH_COUNT - 1) ? LOCKED :
                                    !miss ? CHECK : slip_count == CW'(MAX_SLIPS) ? FAIL : SLIP;
            SLIP:       state_nxt = SLIP_WAIT == 0 ? CHECK : SETTLE;
            SETTLE:     state_nxt = bus.data_valid && settle_cnt == SW'(SLIP_WAIT - 1) ? CHECK : SETTLE;
            LOCKED:     state_nxt = lost ? CHECK : LOCKED;
            default:    state_nxt = state;
         endcase
   end
   // outputs are registered from the next state, so they change on the same edge as the state
   always_comb begin
      match_nxt = match_cnt;
      slip_nxt  = slip_count;
      if (state_nxt inside {IDLE, WAIT_READY} || lost) begin
         match_nxt = '0;
         slip_nxt  = '0;
      end else if (state == CHECK) match_nxt = hit ? match_cnt + 1'b1 : miss ? '0 : match_cnt;
      else if (state == SLIP && slip_count != CW'(MAX_SLIPS)) slip_nxt = slip_count + 1'b1;
      settle_nxt  = state == SETTLE && state_nxt == SETTLE ? settle_cnt + SW'(bus.data_valid) : '0;
      bitslip_nxt = state_nxt != SLIP;
      aligned_nxt = state_nxt == LOCKED;
      fail_nxt    = state_nxt == FAIL;
   end
endmodule

// File: tb/tb_serdes_bitslip_align_ctrl.sv
// tb_serdes_bitslip_align_ctrl: randomized directed bench for the bitslip alignment controller
module tb_serdes_bitslip_align_ctrl;
   localparam logic [2:0] TP = 3'b100;
   localparam int MATCH = 8, SWAIT = 4, MAXS = 6, LOSS = 4;
`ifdef BITSLIP_RELOCK_EN
   localparam bit RELOCK = 1'b1;
`else
   localparam bit RELOCK = 1'b0;
`endif
   logic clk = 1'b0, reset, enable_n, aligned, align_fail;
   logic [2:0] slip_count;
   int errors = 0, checks = 0;
   int ph, run, slips, ign, loss, e_sc;
   bit pend;
   logic e_bs, e_al, e_fail;
   int pulses, vw, last_vw, rot, v0, r0;
   serdes_bitslip_align_ctrl_if #(.WIDTH(3)) bus ();
   serdes_bitslip_align_ctrl dut (
      .clk(clk), .reset(reset), .enable_n(enable_n), .bus(bus.slave),
      .aligned(aligned), .align_fail(align_fail), .slip_count(slip_count)
   );
   always #5 clk = ~clk;
   function automatic logic [2:0] rot3(input int n);
      logic [5:0] d;
      d = {TP, TP};
      return d[5-n -: 3];
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   // reference: phase 0 idle, 1 waiting for DPA, 2 searching, 3 locked, 4 failed
   task automatic model_clear(input int p);
      ph = p; run = 0; slips = 0; ign = 0; loss = 0; pend = 0;
   endtask
   task automatic model_step(input logic en_n, input logic dpa, input logic dv, input logic [2:0] w);
      e_bs = 1'b1;
      if (en_n) model_clear(0);
      else if (!dpa && (ph == 2 || ph == 3)) model_clear(1);
      else
         case (ph)
            0: ph = 1;
            1: if (dpa) begin ph = 2; run = 0; end
            2: begin
               if (pend) begin
                  pend = 0; slips = slips < MAXS ? slips + 1 : slips; ign = SWAIT;
               end else if (dv) begin
                  if (ign > 0) ign--;
                  else if (w == TP) begin run++; if (run == MATCH) ph = 3; end
                  else begin
                     run = 0;
                     if (slips == MAXS) ph = 4;
                     else begin pend = 1; e_bs = 1'b0; end
                  end
               end
            end
            3: if (RELOCK && dv) begin
               loss = w == TP ? 0 : loss + 1;
               if (loss == LOSS) begin ph = 2; run = 0; slips = 0; loss = 0; end
            end
            default: ;
         endcase
      e_al = ph == 3; e_fail = ph == 4; e_sc = slips;
   endtask
   task automatic cyc(input logic r, input logic en, input logic d, input logic v, input logic [2:0] w);
      reset = r; enable_n = en; bus.dpa_ready = d; bus.data_valid = v; bus.data_i = w;
      if (r) begin model_clear(0); e_bs = 1'b1; e_al = 1'b0; e_fail = 1'b0; e_sc = 0; end
      else model_step(en, d, v, w);
      @(posedge clk);
      #1;
      chk("bitslip_n", bus.bitslip_n, e_bs);
      chk("aligned", aligned, e_al);
      chk("align_fail", align_fail, e_fail);
      chk("slip_count", slip_count, e_sc);
      if (v && !r) vw++;
      if (!bus.bitslip_n) begin
         if (pulses > 0) chk("slip_spacing", (vw - last_vw) >= SWAIT + 1, 1);
         last_vw = vw; pulses++; rot = (rot + 1) % 3;
      end
   endtask
   task automatic restart(input int r);
      repeat (2) cyc(0, 1, 1, 0, 3'b000);
      repeat (3) cyc(0, 0, 1, 0, 3'b000);
      pulses = 0; rot = r;
   endtask
   task automatic search(input bit bad, input int limit);
      logic [2:0] w;
      for (int i = 0; i < limit && !aligned && !align_fail; i++) begin
         w = 3'($urandom_range(0, 7));
         if (w == TP) w = 3'b000;
         if (!bad) w = rot3(rot);
         cyc(0, 0, 1, $urandom_range(0, 3) != 0, w);
      end
      chk("search_done", aligned | align_fail, 1);
   endtask
   initial begin
      bus.dpa_ready = 1'b1; bus.data_valid = 1'b0; bus.data_i = 3'b000;
      enable_n = 1'b0; reset = 1'b1;
      model_clear(0); pulses = 0; vw = 0; last_vw = 0; rot = 0;
      repeat (10) cyc(1, 0, 1, 0, 3'b000);
      cyc(0, 0, 1, 0, 3'b000);
      restart(0);
      v0 = vw;
      search(0, 200);
      chk("noslip_lock_words", vw - v0, MATCH);
      chk("noslip_pulses", pulses, 0);
      chk("noslip_slip_count", slip_count, 0);
      chk("noslip_aligned", aligned, 1);
      restart(1);
      search(0, 300);
      chk("rot2_pulses", pulses, 2);
      chk("rot2_slip_count", slip_count, 2);
      chk("rot2_aligned", aligned, 1);
      restart(0);
      search(1, 500);
      chk("fail_pulses", pulses, MAXS);
      chk("fail_flag", align_fail, 1);
      chk("fail_slip_count", slip_count, MAXS);
      repeat (20) cyc(0, 0, 1, 1, 3'b111);
      chk("fail_no_more_slips", pulses, MAXS);
      cyc(0, 1, 1, 0, 3'b000);
      chk("fail_cleared", align_fail, 0);
      restart(2);
      for (int i = 0; i < 100 && pulses == 0; i++) cyc(0, 0, 1, $urandom_range(0, 3) != 0, rot3(rot));
      chk("settle_first_pulse", pulses, 1);
      repeat (3) cyc(0, 0, 1, 1, rot3(rot));
      cyc(0, 0, 0, 1, rot3(rot));
      chk("settle_drop_slip_count", slip_count, 0);
      chk("settle_drop_aligned", aligned, 0);
      cyc(0, 0, 1, 0, 3'b000);
      pulses = 0;
      search(0, 200);
      chk("settle_retry_pulses", pulses, 0);
      chk("settle_retry_slip_count", slip_count, 0);
      chk("settle_retry_aligned", aligned, 1);
      cyc(0, 0, 0, 1, rot3(rot));
      chk("locked_drop_aligned", aligned, 0);
      chk("locked_drop_slip_count", slip_count, 0);
      cyc(0, 0, 1, 0, 3'b000);
      search(0, 200);
      chk("locked_retry_aligned", aligned, 1);
      repeat (3) cyc(0, 0, 1, 1, 3'b011);
      cyc(0, 0, 1, 1, TP);
      chk("loss_3_then_match", aligned, 1);
      repeat (3) cyc(0, 0, 1, 1, 3'b011);
      chk("loss_3", aligned, 1);
      cyc(0, 0, 1, 1, 3'b011);
      chk("loss_4", aligned, !RELOCK);
      pulses = 0;
      search(0, 200);
      chk("loss_relock_aligned", aligned, 1);
      chk("loss_relock_slip_count", slip_count, 0);
      for (int k = 0; k < 3; k++) begin
         r0 = $urandom_range(0, 2);
         restart(r0);
         search(0, 300);
         chk("rand_pulses", pulses, (3 - r0) % 3);
         chk("rand_slip_count", slip_count, (3 - r0) % 3);
         chk("rand_aligned", aligned, 1);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
